// File: rtl/spi_lcd_pkg.sv
// spi_lcd_pkg: panel command set, decoder state encoding and frame
// defaults shared by the LCD SPI receiver and the transmit-side test FSM.
package spi_lcd_pkg;

   localparam logic [7:0] CMD_SLPIN   = 8'h10;
   localparam logic [7:0] CMD_SLPOUT  = 8'h11;
   localparam logic [7:0] CMD_DISPOFF = 8'h28;
   localparam logic [7:0] CMD_DISPON  = 8'h29;
   localparam logic [7:0] CMD_RAMWR   = 8'h2C;
   localparam logic [7:0] CMD_COLMOD  = 8'h3A;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_COLMOD = 2'd1;
   localparam logic [1:0] ST_PIX_HI = 2'd2;
   localparam logic [1:0] ST_PIX_LO = 2'd3;

   localparam int         FRAME_PIXELS_DEF = 57600;
   localparam logic [7:0] COLMOD_RST_DEF   = 8'h66;

endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronises cs/scl/sda/dc, detects scl rises and
// assembles MSB-first bytes; flags a cs rise that cuts a byte short.
module spi_byte_rx
   import spi_lcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cs,
   input  logic       scl,
   input  logic       sda,
   input  logic       dc,
   output logic [7:0] rx_data,
   output logic       rx_dc,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       cs_sync
);

   logic [1:0] cs_q;
   logic [2:0] scl_q;
   logic [1:0] sda_q;
   logic [1:0] dc_q;
   logic       scl_rise;
   logic [6:0] shreg;
   logic [2:0] bit_cnt;

   assign cs_sync = cs_q[1];

   // scl_rise is registered, so sda/dc are taken one cycle after the edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cs_q      <= 2'b11;
         scl_q     <= '0;
         sda_q     <= '0;
         dc_q      <= '0;
         scl_rise  <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
         rx_data   <= '0;
         rx_dc     <= 1'b0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cs_q      <= {cs_q[0], cs};
         scl_q     <= {scl_q[1:0], scl};
         sda_q     <= {sda_q[0], sda};
         dc_q      <= {dc_q[0], dc};
         scl_rise  <= scl_q[1] & ~scl_q[2];
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         if (cs_q[1]) begin
            frame_err <= (bit_cnt != 3'd0);
            bit_cnt   <= '0;
            shreg     <= '0;
         end else if (scl_rise) begin
            if (bit_cnt == 3'd7) begin
               rx_data  <= {shreg, sda_q[1]};
               rx_dc    <= dc_q[1];
               rx_valid <= 1'b1;
               bit_cnt  <= '0;
               shreg    <= '0;
            end else begin
               shreg   <= {shreg[5:0], sda_q[1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/spi_lcd_rx.sv
// spi_lcd_rx: LCD-side SPI receiver with panel command decoder,
// RGB565 pixel pairing and per-frame pixel counter.
module spi_lcd_rx
   import spi_lcd_pkg::*;
#(
   parameter int         FRAME_PIXELS = FRAME_PIXELS_DEF,
   parameter logic [7:0] COLMOD_RST   = COLMOD_RST_DEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cs,
   input  logic        scl,
   input  logic        sda,
   input  logic        dc,
   output logic [7:0]  rx_data,
   output logic        rx_dc,
   output logic        rx_valid,
   output logic        frame_err,
   output logic [15:0] pixel,
   output logic        pixel_valid,
   output logic [15:0] pixel_count,
   output logic        frame_done,
   output logic        sleep_out,
   output logic        display_on,
   output logic        ram_wr_active,
   output logic [7:0]  colmod
);

   localparam logic [15:0] LAST_PIX = 16'(FRAME_PIXELS - 1);

   logic       cs_sync;
   logic [1:0] state;
   logic [7:0] hi_byte;

   spi_byte_rx u_byte_rx (
      .clk       (clk),
      .reset_n   (reset_n),
      .cs        (cs),
      .scl       (scl),
      .sda       (sda),
      .dc        (dc),
      .rx_data   (rx_data),
      .rx_dc     (rx_dc),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .cs_sync   (cs_sync)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= ST_IDLE;
         hi_byte       <= '0;
         pixel         <= '0;
         pixel_valid   <= 1'b0;
         pixel_count   <= '0;
         frame_done    <= 1'b0;
         sleep_out     <= 1'b0;
         display_on    <= 1'b0;
         ram_wr_active <= 1'b0;
         colmod        <= COLMOD_RST;
      end else begin
         pixel_valid <= 1'b0;
         frame_done  <= 1'b0;
         if (rx_valid && !rx_dc) begin
            ram_wr_active <= 1'b0;
            state         <= ST_IDLE;
            case (rx_data)
               CMD_SLPOUT:  sleep_out  <= 1'b1;
               CMD_SLPIN:   sleep_out  <= 1'b0;
               CMD_DISPON:  display_on <= 1'b1;
               CMD_DISPOFF: display_on <= 1'b0;
               CMD_COLMOD:  state      <= ST_COLMOD;
               CMD_RAMWR: begin
                  ram_wr_active <= 1'b1;
                  pixel_count   <= '0;
                  state         <= ST_PIX_HI;
               end
               default: ;
            endcase
         end else if (rx_valid) begin
            unique case (state)
               ST_COLMOD: begin
                  colmod <= rx_data;
                  state  <= ST_IDLE;
               end
               ST_PIX_HI: begin
                  hi_byte <= rx_data;
                  state   <= ST_PIX_LO;
               end
               ST_PIX_LO: begin
                  pixel       <= {hi_byte, rx_data};
                  pixel_valid <= 1'b1;
                  state       <= ST_PIX_HI;
                  if (pixel_count == LAST_PIX) begin
                     pixel_count <= '0;
                     frame_done  <= 1'b1;
                  end else begin
                     pixel_count <= pixel_count + 16'd1;
                  end
               end
               default: ;
            endcase
         end else if (cs_sync && state == ST_PIX_LO) begin
            // a high byte left over when the frame closes never pairs up
            state <= ST_PIX_HI;
         end
      end
   end

endmodule

// File: tb/tb_spi_lcd_rx.sv
// tb_spi_lcd_rx: scoreboard bench for spi_lcd_rx with a byte-level
// panel model, directed sequences and randomized command/data traffic.
module tb_spi_lcd_rx;

   localparam int FP = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        cs = 1'b1;
   logic        scl = 1'b0;
   logic        sda = 1'b0;
   logic        dc = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_dc;
   logic        rx_valid;
   logic        frame_err;
   logic [15:0] pixel;
   logic        pixel_valid;
   logic [15:0] pixel_count;
   logic        frame_done;
   logic        sleep_out;
   logic        display_on;
   logic        ram_wr_active;
   logic [7:0]  colmod;

   always #5 clk = ~clk;

   spi_lcd_rx #(.FRAME_PIXELS(FP), .COLMOD_RST(8'h66)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .cs            (cs),
      .scl           (scl),
      .sda           (sda),
      .dc            (dc),
      .rx_data       (rx_data),
      .rx_dc         (rx_dc),
      .rx_valid      (rx_valid),
      .frame_err     (frame_err),
      .pixel         (pixel),
      .pixel_valid   (pixel_valid),
      .pixel_count   (pixel_count),
      .frame_done    (frame_done),
      .sleep_out     (sleep_out),
      .display_on    (display_on),
      .ram_wr_active (ram_wr_active),
      .colmod        (colmod)
   );

   int checks = 0;
   int failures = 0;

   logic [8:0]  rx_q[$];
   logic [32:0] pix_q[$];

   // panel model: mode 0 idle, 1 colmod param, 2 pixel high, 3 pixel low
   int         m_mode;
   logic       m_sleep, m_disp, m_ram;
   logic [7:0] m_colmod, m_hi;
   logic [15:0] m_pixel;
   int         m_cnt;
   int         m_ferr;
   int         ferr_seen = 0;
   int         partial;

   logic [8:0]  rx_e;
   logic [32:0] px_e;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_sleep = 0;
      m_disp = 0;
      m_ram = 0;
      m_colmod = 8'h66;
      m_hi = 0;
      m_pixel = 0;
      m_cnt = 0;
      partial = 0;
   endtask

   task automatic model_byte(logic [7:0] b, logic d);
      logic fd;
      rx_q.push_back({d, b});
      if (!d) begin
         m_ram = 0;
         m_mode = 0;
         if (b == 8'h11) m_sleep = 1;
         if (b == 8'h10) m_sleep = 0;
         if (b == 8'h29) m_disp = 1;
         if (b == 8'h28) m_disp = 0;
         if (b == 8'h3A) m_mode = 1;
         if (b == 8'h2C) begin
            m_ram = 1;
            m_cnt = 0;
            m_mode = 2;
         end
      end else if (m_mode == 1) begin
         m_colmod = b;
         m_mode = 0;
      end else if (m_mode == 2) begin
         m_hi = b;
         m_mode = 3;
      end else if (m_mode == 3) begin
         m_pixel = {m_hi, b};
         m_cnt = (m_cnt + 1) % FP;
         fd = (m_cnt == 0);
         pix_q.push_back({fd, 16'(m_cnt), m_pixel});
         m_mode = 2;
      end
   endtask

   task automatic send_bit(logic b, logic d);
      @(negedge clk);
      sda = b;
      dc = d;
      repeat (4) @(negedge clk);
      scl = 1'b1;
      repeat (4) @(negedge clk);
      scl = 1'b0;
   endtask

   task automatic send_byte(logic [7:0] b, logic d);
      model_byte(b, d);
      for (int i = 7; i >= 0; i--) send_bit(b[i], d);
   endtask

   task automatic send_bits(int n);
      for (int i = 0; i < n; i++) send_bit(1'($urandom), 1'b1);
      partial = n;
   endtask

   task automatic cs_low();
      @(negedge clk);
      cs = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      repeat (4) @(negedge clk);
      cs = 1'b1;
      if (partial != 0) m_ferr++;
      partial = 0;
      if (m_mode == 3) m_mode = 2;
      repeat (6) @(negedge clk);
   endtask

   task automatic checkpoint(string t);
      repeat (12) @(negedge clk);
      chk({t, ".sleep_out"}, sleep_out, m_sleep);
      chk({t, ".display_on"}, display_on, m_disp);
      chk({t, ".ram_wr_active"}, ram_wr_active, m_ram);
      chk({t, ".colmod"}, colmod, m_colmod);
      chk({t, ".pixel_count"}, pixel_count, m_cnt);
      chk({t, ".pixel"}, pixel, m_pixel);
      chk({t, ".frame_err_count"}, ferr_seen, m_ferr);
      chk({t, ".rx_pending"}, rx_q.size(), 0);
      chk({t, ".pix_pending"}, pix_q.size(), 0);
   endtask

   task automatic check_reset_values(string t);
      chk({t, ".rx_data"}, rx_data, 0);
      chk({t, ".rx_dc"}, rx_dc, 0);
      chk({t, ".rx_valid"}, rx_valid, 0);
      chk({t, ".frame_err"}, frame_err, 0);
      chk({t, ".pixel"}, pixel, 0);
      chk({t, ".pixel_valid"}, pixel_valid, 0);
      chk({t, ".pixel_count"}, pixel_count, 0);
      chk({t, ".frame_done"}, frame_done, 0);
      chk({t, ".sleep_out"}, sleep_out, 0);
      chk({t, ".display_on"}, display_on, 0);
      chk({t, ".ram_wr_active"}, ram_wr_active, 0);
      chk({t, ".colmod"}, colmod, 8'h66);
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (frame_err) ferr_seen++;
         if (rx_valid) begin
            if (rx_q.size() == 0) begin
               chk("rx_unexpected", {rx_dc, rx_data}, 9'h1ff);
               if ({rx_dc, rx_data} == 9'h1ff) chk("rx_unexpected", 0, 1);
            end else begin
               rx_e = rx_q.pop_front();
               chk("rx_byte", {rx_dc, rx_data}, rx_e);
            end
         end
         if (pixel_valid) begin
            if (pix_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL pix_unexpected actual=%0h expected=none", pixel);
            end else begin
               px_e = pix_q.pop_front();
               chk("pixel_out", {frame_done, pixel_count, pixel}, px_e);
            end
         end else if (frame_done) begin
            checks++;
            failures++;
            $display("FAIL frame_done_alone actual=1 expected=0");
         end
      end
   end

   logic [7:0] cmds[7];

   initial begin
      cmds = '{8'h10, 8'h11, 8'h28, 8'h29, 8'h3A, 8'h2C, 8'h2C};
      model_reset();
      m_ferr = 0;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset_n = 1'b1;
      repeat (3) @(negedge clk);

      cs_low();
      send_byte(8'h11, 0);
      send_byte(8'h29, 0);
      send_byte(8'h3A, 0);
      send_byte(8'h55, 1);
      send_byte(8'h2C, 0);
      cs_high();
      checkpoint("init");

      cs_low();
      send_byte(8'hF8, 1);
      send_byte(8'h00, 1);
      cs_high();
      checkpoint("px1");
      cs_low();
      send_byte(8'h07, 1);
      send_byte(8'hE0, 1);
      cs_high();
      checkpoint("px2");

      cs_low();
      send_bits(5);
      cs_high();
      checkpoint("partial");
      cs_low();
      send_byte(8'hA5, 1);
      cs_high();
      checkpoint("after_partial");
      chk("rx_a5", rx_data, 8'hA5);

      cs_low();
      send_byte(8'h00, 1);
      cs_high();
      cs_low();
      send_byte(8'h00, 1);
      send_byte(8'h1F, 1);
      cs_high();
      checkpoint("dangle");

      cs_low();
      send_byte(8'h12, 1);
      send_byte(8'h34, 1);
      cs_high();
      checkpoint("wrap");
      cs_low();
      send_byte(8'h28, 0);
      send_byte(8'h56, 1);
      send_byte(8'h78, 1);
      cs_high();
      checkpoint("dispoff");

      cs_low();
      send_byte(8'h3A, 0);
      send_byte(8'h77, 1);
      send_byte(8'h2C, 0);
      send_byte(8'hAB, 1);
      checkpoint("pre_reset");
      send_bits(4);
      @(negedge clk);
      reset_n = 1'b0;
      cs = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_values("mid_reset");
      model_reset();
      reset_n = 1'b1;
      checkpoint("post_reset");

      cs_low();
      for (int i = 0; i < 90; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r <= 4) send_byte(cmds[$urandom_range(0, 6)], 0);
         else if (r == 5) send_byte(8'($urandom), 0);
         else if (r <= 17) send_byte(8'($urandom), 1);
         else if (r == 18) begin
            cs_high();
            cs_low();
         end else begin
            send_bits($urandom_range(1, 7));
            cs_high();
            cs_low();
         end
      end
      cs_high();
      checkpoint("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
